// File: rtl/deserializer.sv
// HS receive deserializer: hunts for the leader sync byte on a two-bit-per-clock
// stream, then reassembles aligned bytes with a one-cycle valid strobe.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | receiver disabled; shift register and counters held clear
// HUNT    | shifting every pair, comparing against SYNC_WORD at any phase
// RECEIVE | aligned; one byte delivered every fourth pair
// ERR     | sync not found in time; outputs idle until enable drops
module deserializer #(
  parameter logic [7:0] SYNC_WORD    = 8'hB8,
  parameter int         SYNC_TIMEOUT = 64
) (
  input  logic       RxDDRClkHS,
  input  logic       RxRst,
  input  logic       deserializer_en,
  input  logic       Serial_Bit1,
  input  logic       Serial_Bit2,
  output logic [7:0] RxByteHS_Data,
  output logic       RxValidHS,
  output logic       RxActiveHS,
  output logic       RxSyncHS,
  output logic       ErrSotSyncHS
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HUNT = 2'd1;
  localparam logic [1:0] S_RECV = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [7:0] TMO_LIMIT = 8'(SYNC_TIMEOUT);

  logic [1:0] state_q, state_d;
  logic [7:0] sh_q, sh_d;
  logic [1:0] pcnt_q, pcnt_d;
  logic [7:0] tmo_q, tmo_d;
  logic [7:0] byte_q, byte_d;
  logic       valid_q, valid_d;
  logic       active_q, active_d;
  logic       sync_q, sync_d;
  logic       err_q, err_d;

  logic [7:0] next_sh;
  logic [7:0] tmo_inc;

  // Odd bit lands above the even bit; oldest pair ends up in sh[1:0].
  assign next_sh = {Serial_Bit1, Serial_Bit2, sh_q[7:2]};
  assign tmo_inc = tmo_q + 8'd1;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    pcnt_d  = pcnt_q;
    tmo_d   = tmo_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    sync_d  = 1'b0;
    err_d   = 1'b0;

    if (!deserializer_en) begin
      // A pair sampled while enable is low is never part of a byte.
      state_d = S_IDLE;
      sh_d    = 8'h00;
      pcnt_d  = 2'd0;
      tmo_d   = 8'h00;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_HUNT;
          sh_d    = 8'h00;
          pcnt_d  = 2'd0;
          tmo_d   = 8'h00;
        end
        S_HUNT: begin
          sh_d  = next_sh;
          tmo_d = tmo_inc;
          if (next_sh == SYNC_WORD) begin
            state_d = S_RECV;
            sync_d  = 1'b1;
            pcnt_d  = 2'd0;
          end else if (tmo_inc == TMO_LIMIT) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
        S_RECV: begin
          sh_d   = next_sh;
          pcnt_d = pcnt_q + 2'd1;
          if (pcnt_q == 2'd3) begin
            byte_d  = next_sh;
            valid_d = 1'b1;
          end
        end
        default: begin
          sh_d = 8'h00;
        end
      endcase
    end

    active_d = (state_d == S_RECV);
  end

  always_ff @(posedge RxDDRClkHS) begin
    if (RxRst) begin
      state_q  <= S_IDLE;
      sh_q     <= 8'h00;
      pcnt_q   <= 2'd0;
      tmo_q    <= 8'h00;
      byte_q   <= 8'h00;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
      sync_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      pcnt_q   <= pcnt_d;
      tmo_q    <= tmo_d;
      byte_q   <= byte_d;
      valid_q  <= valid_d;
      active_q <= active_d;
      sync_q   <= sync_d;
      err_q    <= err_d;
    end
  end

  assign RxByteHS_Data = byte_q;
  assign RxValidHS     = valid_q;
  assign RxActiveHS    = active_q;
  assign RxSyncHS      = sync_q;
  assign ErrSotSyncHS  = err_q;

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for the HS deserializer; a second instance with a short
// sync timeout covers the timeout and match-on-timeout cases.
module tb_deserializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, b1, b2;
  logic [7:0] data, data_t;
  logic valid, active, sync, err;
  logic valid_t, active_t, sync_t, err_t;

  deserializer dut (
    .RxDDRClkHS(clk), .RxRst(rst), .deserializer_en(en),
    .Serial_Bit1(b1), .Serial_Bit2(b2),
    .RxByteHS_Data(data), .RxValidHS(valid), .RxActiveHS(active),
    .RxSyncHS(sync), .ErrSotSyncHS(err)
  );

  deserializer #(.SYNC_TIMEOUT(8)) dut_t (
    .RxDDRClkHS(clk), .RxRst(rst), .deserializer_en(en),
    .Serial_Bit1(b1), .Serial_Bit2(b2),
    .RxByteHS_Data(data_t), .RxValidHS(valid_t), .RxActiveHS(active_t),
    .RxSyncHS(sync_t), .ErrSotSyncHS(err_t)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: records delivered bytes and pulse events for both instances.
  logic [7:0] rx_q[$];
  int         rx_cyc[$];
  logic [7:0] rxt_q[$];
  int sync_cnt = 0, err_cnt = 0, sync_t_cnt = 0, err_t_cnt = 0, err_t_cyc = 0;
  int viol = 0;
  logic pv = 1'b0, ps = 1'b0, pe = 1'b0, pvt = 1'b0, pst = 1'b0, pet = 1'b0;

  always @(negedge clk) begin
    if (valid) begin
      rx_q.push_back(data);
      rx_cyc.push_back(cyc);
    end
    if (valid_t) rxt_q.push_back(data_t);
    if (sync) sync_cnt <= sync_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
    if (sync_t) sync_t_cnt <= sync_t_cnt + 1;
    if (err_t) begin
      err_t_cnt <= err_t_cnt + 1;
      err_t_cyc <= cyc;
    end
    if ((valid && pv) || (sync && ps) || (err && pe) ||
        (valid_t && pvt) || (sync_t && pst) || (err_t && pet))
      viol <= viol + 1;
    pv <= valid; ps <= sync; pe <= err;
    pvt <= valid_t; pst <= sync_t; pet <= err_t;
  end

  task automatic pair(input logic x1, input logic x0);
    b1 = x1;
    b2 = x0;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int k = 0; k < 4; k++) pair(v[2*k+1], v[2*k]);
  endtask

  task automatic go_idle();
    en = 1'b0;
    pair(1'b0, 1'b0);
    pair(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1;
    pair(1'b0, 1'b0);
    pair(1'b0, 1'b0);
    tests++;
    if (data !== 8'h00) begin
      fails++; $display("FAIL reset_data: got %h expected 00", data);
    end
    tests++;
    if ({valid, active, sync, err} !== 4'b0000) begin
      fails++; $display("FAIL reset_flags: got %b expected 0000", {valid, active, sync, err});
    end
    tests++;
    if ({data_t, valid_t, active_t, sync_t, err_t} !== 12'h000) begin
      fails++; $display("FAIL reset_t: got %h expected 000", {data_t, valid_t, active_t, sync_t, err_t});
    end
    rst = 1'b0; en = 1'b0;
    pair(1'b0, 1'b0);
  endtask

  task automatic test_aligned_burst();
    int b, s0;
    b = rx_q.size(); s0 = sync_cnt;
    en = 1'b1;
    repeat (6) pair(1'b0, 1'b0);
    send_byte(8'hB8);
    tests++;
    if ({sync, active} !== 2'b11) begin
      fails++; $display("FAIL burst_sync_now: got sync/active %b expected 11", {sync, active});
    end
    send_byte(8'h5A);
    send_byte(8'hC3);
    @(negedge clk); #1;
    tests++;
    if (rx_q.size() - b !== 2) begin
      fails++; $display("FAIL burst_count: got %0d expected 2", rx_q.size() - b);
    end else begin
      tests++;
      if (rx_q[b] !== 8'h5A) begin
        fails++; $display("FAIL burst_byte0: got %h expected 5a", rx_q[b]);
      end
      tests++;
      if (rx_q[b+1] !== 8'hC3) begin
        fails++; $display("FAIL burst_byte1: got %h expected c3", rx_q[b+1]);
      end
      tests++;
      if (rx_cyc[b+1] - rx_cyc[b] !== 4) begin
        fails++; $display("FAIL burst_gap: got %0d expected 4", rx_cyc[b+1] - rx_cyc[b]);
      end
    end
    tests++;
    if (sync_cnt - s0 !== 1) begin
      fails++; $display("FAIL burst_sync_cnt: got %0d expected 1", sync_cnt - s0);
    end
    en = 1'b0;
    pair(1'b0, 1'b0);
    tests++;
    if ({active, data} !== {1'b0, 8'hC3}) begin
      fails++; $display("FAIL burst_end: got active %b data %h expected 0 c3", active, data);
    end
    pair(1'b0, 1'b0);
  endtask

  task automatic test_odd_leader();
    int b, s0;
    b = rx_q.size(); s0 = sync_cnt;
    en = 1'b1;
    repeat (3) pair(1'b0, 1'b0);
    send_byte(8'hB8);
    send_byte(8'hFF);
    send_byte(8'h00);
    send_byte(8'hB8);
    @(negedge clk); #1;
    tests++;
    if (rx_q.size() - b !== 3) begin
      fails++; $display("FAIL odd_count: got %0d expected 3", rx_q.size() - b);
    end else begin
      tests++;
      if ({rx_q[b], rx_q[b+1], rx_q[b+2]} !== 24'hFF00B8) begin
        fails++; $display("FAIL odd_bytes: got %h%h%h expected ff00b8", rx_q[b], rx_q[b+1], rx_q[b+2]);
      end
    end
    tests++;
    if (sync_cnt - s0 !== 1) begin
      fails++; $display("FAIL odd_sync_cnt: got %0d expected 1", sync_cnt - s0);
    end
    go_idle();
  endtask

  task automatic test_timeout();
    int e0, s0, bt, t0;
    e0 = err_t_cnt; s0 = sync_t_cnt; bt = rxt_q.size();
    en = 1'b1;
    pair(1'b0, 1'b0);
    t0 = cyc;
    repeat (12) pair(1'b0, 1'b0);
    @(negedge clk); #1;
    tests++;
    if (err_t_cnt - e0 !== 1) begin
      fails++; $display("FAIL tmo_err_cnt: got %0d expected 1", err_t_cnt - e0);
    end
    tests++;
    if (err_t_cyc - t0 !== 8) begin
      fails++; $display("FAIL tmo_latency: got %0d expected 8", err_t_cyc - t0);
    end
    tests++;
    if ({err_t, active_t, valid_t} !== 3'b000 || rxt_q.size() !== bt) begin
      fails++; $display("FAIL tmo_idle: got flags %b bytes %0d expected 000 0", {err_t, active_t, valid_t}, rxt_q.size() - bt);
    end
    go_idle();
    en = 1'b1;
    pair(1'b0, 1'b0);
    send_byte(8'hB8);
    send_byte(8'h3C);
    @(negedge clk); #1;
    tests++;
    if (rxt_q.size() - bt !== 1) begin
      fails++; $display("FAIL tmo_resume_count: got %0d expected 1", rxt_q.size() - bt);
    end else begin
      tests++;
      if (rxt_q[bt] !== 8'h3C) begin
        fails++; $display("FAIL tmo_resume_byte: got %h expected 3c", rxt_q[bt]);
      end
    end
    tests++;
    if ({err_t_cnt - e0, sync_t_cnt - s0} !== {32'd1, 32'd1}) begin
      fails++; $display("FAIL tmo_resume_pulses: got err %0d sync %0d expected 1 1", err_t_cnt - e0, sync_t_cnt - s0);
    end
    go_idle();
  endtask

  task automatic test_sync_at_timeout();
    int e0;
    e0 = err_t_cnt;
    en = 1'b1;
    pair(1'b0, 1'b0);
    repeat (4) pair(1'b0, 1'b0);
    send_byte(8'hB8);
    tests++;
    if ({sync_t, active_t, err_t} !== 3'b110) begin
      fails++; $display("FAIL edge_match: got sync/active/err %b expected 110", {sync_t, active_t, err_t});
    end
    pair(1'b0, 1'b0);
    pair(1'b0, 1'b0);
    tests++;
    if (err_t_cnt - e0 !== 0) begin
      fails++; $display("FAIL edge_no_err: got %0d expected 0", err_t_cnt - e0);
    end
    go_idle();
  endtask

  task automatic test_enable_drop();
    int b;
    logic [7:0] v;
    b = rx_q.size();
    v = 8'h71;
    en = 1'b1;
    pair(1'b0, 1'b0);
    send_byte(8'hB8);
    send_byte(8'h96);
    pair(v[1], v[0]);
    pair(v[3], v[2]);
    en = 1'b0;
    pair(v[5], v[4]);
    tests++;
    if ({active, data} !== {1'b0, 8'h96}) begin
      fails++; $display("FAIL drop_now: got active %b data %h expected 0 96", active, data);
    end
    pair(v[7], v[6]);
    repeat (3) pair(1'b0, 1'b0);
    @(negedge clk); #1;
    tests++;
    if (rx_q.size() - b !== 1) begin
      fails++; $display("FAIL drop_count: got %0d expected 1", rx_q.size() - b);
    end else begin
      tests++;
      if (rx_q[b] !== 8'h96) begin
        fails++; $display("FAIL drop_byte: got %h expected 96", rx_q[b]);
      end
    end
    tests++;
    if (data !== 8'h96) begin
      fails++; $display("FAIL drop_hold: got %h expected 96", data);
    end
  endtask

  task automatic test_reset_midburst();
    int b;
    logic [7:0] v;
    b = rx_q.size();
    v = 8'hA5;
    en = 1'b1;
    pair(1'b0, 1'b0);
    send_byte(8'hB8);
    send_byte(8'h11);
    pair(v[1], v[0]);
    pair(v[3], v[2]);
    rst = 1'b1;
    pair(v[5], v[4]);
    tests++;
    if ({data, valid, active, sync, err} !== 12'h000) begin
      fails++; $display("FAIL rst_mid: got %h expected 000", {data, valid, active, sync, err});
    end
    rst = 1'b0;
    pair(1'b0, 1'b0);
    send_byte(8'hB8);
    send_byte(8'hE7);
    @(negedge clk); #1;
    tests++;
    if (rx_q.size() - b !== 2) begin
      fails++; $display("FAIL rst_count: got %0d expected 2", rx_q.size() - b);
    end else begin
      tests++;
      if ({rx_q[b], rx_q[b+1]} !== 16'h11E7) begin
        fails++; $display("FAIL rst_bytes: got %h%h expected 11e7", rx_q[b], rx_q[b+1]);
      end
    end
    go_idle();
  endtask

  task automatic test_loopback();
    int b, s0, bad_data, bad_gap;
    logic [7:0] pl[256];
    b = rx_q.size(); s0 = sync_cnt;
    for (int i = 0; i < 256; i++) pl[i] = 8'($urandom_range(0, 255));
    en = 1'b1;
    pair(1'b0, 1'b0);
    send_byte(8'hB8);
    for (int i = 0; i < 256; i++) send_byte(pl[i]);
    @(negedge clk); #1;
    tests++;
    if (rx_q.size() - b !== 256) begin
      fails++; $display("FAIL loop_count: got %0d expected 256", rx_q.size() - b);
    end else begin
      bad_data = 0; bad_gap = 0;
      for (int i = 0; i < 256; i++) begin
        if (rx_q[b+i] !== pl[i]) bad_data++;
        if (i > 0 && rx_cyc[b+i] - rx_cyc[b+i-1] != 4) bad_gap++;
      end
      tests++;
      if (bad_data !== 0) begin
        fails++; $display("FAIL loop_data: got %0d wrong bytes expected 0", bad_data);
      end
      tests++;
      if (bad_gap !== 0) begin
        fails++; $display("FAIL loop_gap: got %0d irregular gaps expected 0", bad_gap);
      end
    end
    tests++;
    if (sync_cnt - s0 !== 1) begin
      fails++; $display("FAIL loop_sync_cnt: got %0d expected 1", sync_cnt - s0);
    end
    go_idle();
  endtask

  task automatic test_pulse_width();
    tests++;
    if (viol !== 0) begin
      fails++; $display("FAIL pulse_width: got %0d multi-cycle pulses expected 0", viol);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; b1 = 1'b0; b2 = 1'b0;
    test_reset();
    test_aligned_burst();
    test_odd_leader();
    test_timeout();
    test_sync_at_timeout();
    test_enable_drop();
    test_reset_midburst();
    test_loopback();
    test_pulse_width();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
